cdc_gray_fifo_rd: RTL

// - Read (destination) half of a gray-pointer asynchronous FIFO, clocked in the destination domain.
// - Takes the write half's memory image and gray write pointer, and returns a gray read pointer.
// - Presents entries on a valid/ready stream that feeds one AXI channel
//   (AW/W/AR requests, or the B/R response path) inside the destination-side CDC.
// - Constraints on async_* paths: max_delay <= min(src,dst) period, no hold fixing; documented per instance.

---
 rtl/cdc_gray_pkg.sv | 24 ++
 rtl/cdc_sync_ah.sv | 31 +++
 rtl/cdc_gray_fifo_rd.sv | 95 +++++++++
 3 files changed

// File: rtl/cdc_gray_pkg.sv
// Gray-code helpers and limits shared by both halves of the asynchronous FIFO.
package cdc_gray_pkg;

  localparam int MaxLogDepth = 8;
  localparam int MaxPtrWidth = MaxLogDepth + 1;

  typedef logic [MaxPtrWidth-1:0] ptr_max_t;

  // Narrower pointers are zero-extended by the caller. Leading zeros leave both
  // conversions unchanged, so one pair of functions serves every pointer width.
  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_sync_ah.sv
// Multi-bit flop-chain synchronizer with asynchronous active-high reset.
// Only safe for buses where at most one bit changes per sample, such as gray pointers.
module cdc_sync_ah #(
  parameter int Width      = 1,
  parameter int SyncStages = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_chain [SyncStages];

  // Shift the input straight into the first flop with no logic in front of it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SyncStages; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < SyncStages; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[SyncStages-1];

endmodule

// File: rtl/cdc_gray_fifo_rd.sv
// Read half of a gray-pointer asynchronous FIFO, living entirely in the destination
// clock domain. The memory and gray write pointer come from the write half; this
// block returns a gray read pointer and presents entries on a valid/ready stream.
// LogDepth must lie in 1..MaxLogDepth and SyncStages must be at least 2.
module cdc_gray_fifo_rd
  import cdc_gray_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int LogDepth   = 1,
  parameter int SyncStages = 2
) (
  input  logic                                dst_clk_i,
  input  logic                                dst_rst_i,
  input  logic [(2**LogDepth)*DataWidth-1:0]  async_data_i,
  input  logic [LogDepth:0]                   async_wptr_i,
  output logic [LogDepth:0]                   async_rptr_o,
  output logic [DataWidth-1:0]                dst_data_o,
  output logic                                dst_valid_o,
  input  logic                                dst_ready_i
);

  localparam int PtrW  = LogDepth + 1;
  localparam int Depth = 1 << LogDepth;

  logic [PtrW-1:0]      r_rptrBin;
  logic [PtrW-1:0]      r_rptrGray;
  logic [DataWidth-1:0] r_data;
  logic                 r_valid;

  logic [PtrW-1:0]      w_wptrSync;
  logic [PtrW-1:0]      w_rptrBinNext;
  logic [PtrW-1:0]      w_rptrGrayNext;
  logic [LogDepth-1:0]  w_rdIdx;
  logic [DataWidth-1:0] w_headData;
  logic                 w_empty;
  logic                 w_pop;

  cdc_sync_ah #(
    .Width      (PtrW),
    .SyncStages (SyncStages)
  ) u_wptrSync (
    .i_clk (dst_clk_i),
    .i_rst (dst_rst_i),
    .i_d   (async_wptr_i),
    .o_q   (w_wptrSync)
  );

  // The extra pointer MSB separates "empty" from "full", so equality always means empty.
  assign w_empty        = (w_wptrSync == r_rptrGray);
  assign w_pop          = !w_empty && (!r_valid || dst_ready_i);
  assign w_rptrBinNext  = r_rptrBin + 1'b1;
  assign w_rptrGrayNext = PtrW'(bin2gray(ptr_max_t'(w_rptrBinNext)));
  assign w_rdIdx        = r_rptrBin[LogDepth-1:0];
  assign w_headData     = async_data_i[w_rdIdx*DataWidth +: DataWidth];

  // Load the head entry into the output register whenever it is free or being taken,
  // advancing both pointer views on the same edge so the gray copy is glitch-free.
  always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
    if (dst_rst_i) begin
      r_rptrBin  <= '0;
      r_rptrGray <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else if (w_pop) begin
      r_data     <= w_headData;
      r_valid    <= 1'b1;
      r_rptrBin  <= w_rptrBinNext;
      r_rptrGray <= w_rptrGrayNext;
    end else if (dst_ready_i) begin
      r_valid    <= 1'b0;
    end
  end

  assign async_rptr_o = r_rptrGray;
  assign dst_data_o   = r_data;
  assign dst_valid_o  = r_valid;

`ifndef SYNTHESIS
  logic [PtrW-1:0] w_wptrSyncBin;
  logic [PtrW-1:0] w_occupancy;

  assign w_wptrSyncBin = PtrW'(gray2bin(ptr_max_t'(w_wptrSync)));
  assign w_occupancy   = w_wptrSyncBin - r_rptrBin;

  a_occupancy : assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
    int'(w_occupancy) <= Depth);

  a_wptrOneBit : assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
    $countones(w_wptrSync ^ $past(w_wptrSync)) <= 1);

  a_holdUnderBackpressure : assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
    (dst_valid_o && !dst_ready_i) |=> (dst_valid_o && $stable(dst_data_o)));
`endif

endmodule
